// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit: IF-stage PC control.
// Arbitrates redirects, load-use stalls and imem wait states.
module pc_ctrl_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic             stall,
  output logic             jump_cs,
  output logic [31:0]      Next_pc,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {
    RUN,
    PEND
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic        load_use;
  logic        redir;
  logic [31:0] redir_tgt;

  // Hazard and redirect request decode from ID/EX.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) ||
                (id_uses_rt && (ex_rt == id_rt)));
    redir     = ex_branch_taken || id_jump;
    redir_tgt = ex_branch_taken ? ex_branch_target
                                : id_jump_target;
  end

  // PC control outputs and next-state selection.
  always_comb begin
    stall         = 1'b0;
    jump_cs       = 1'b0;
    Next_pc       = pend_target_q;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    state_d       = state_q;
    pend_target_d = pend_target_q;
    if (rst) begin
      jump_cs       = 1'b1;
      Next_pc       = RESET_PC;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      state_d       = RUN;
      pend_target_d = 32'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (redir) begin
            ifid_flush  = 1'b1;
            idex_bubble = ex_branch_taken;
            if (imem_ready) begin
              jump_cs = 1'b1;
              Next_pc = redir_tgt;
            end else begin
              stall         = 1'b1;
              pend_target_d = redir_tgt;
              state_d       = PEND;
            end
          end else if (load_use) begin
            stall       = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            stall = !imem_ready;
          end
        end
        PEND: begin
          ifid_flush = 1'b1;
          stall      = !imem_ready;
          jump_cs    = imem_ready;
          if (imem_ready) state_d = RUN;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
      redir_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (jump_cs && !(&redir_cnt_q))
        redir_cnt_d = redir_cnt_q + CNT_ONE;
    end
  end

  // State, pending target and counter registers.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    pend_target_q <= pend_target_d;
    stall_cnt_q   <= stall_cnt_d;
    redir_cnt_q   <= redir_cnt_d;
  end

  assign stall_count    = stall_cnt_q;
  assign redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// tb_pc_ctrl_unit: scoreboard bench for pc_ctrl_unit.
// Drives a PC model from DUT outputs, checks against a spec model.
module tb_pc_ctrl_unit;

  localparam logic [31:0] RST_PC = 32'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, id_jump = 1'b0;
  logic        ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic [31:0] id_jump_target = '0, ex_branch_target = '0;

  logic        stall0, jcs0, fl0, bb0;
  logic [31:0] npc0, sc0, rc0;
  logic        stall1, jcs1, fl1, bb1;
  logic [31:0] npc1;
  logic [3:0]  sc1, rc1;

  pc_ctrl_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .stall(stall0), .jump_cs(jcs0), .Next_pc(npc0),
    .ifid_flush(fl0), .idex_bubble(bb0),
    .stall_count(sc0), .redirect_count(rc0));

  pc_ctrl_unit #(.RESET_PC(RST_PC), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .stall(stall1), .jump_cs(jcs1), .Next_pc(npc1),
    .ifid_flush(fl1), .idex_bubble(bb1),
    .stall_count(sc1), .redirect_count(rc1));

  // The program counter that the unit controls.
  logic [31:0] pc_q;
  always @(posedge clk) begin
    if (jcs0)        pc_q <= npc0;
    else if (!stall0) pc_q <= pc_q + 32'd1;
  end

  typedef struct {
    bit          rst, rdy, use_rt, jmp, mr, bt;
    logic [4:0]  rs, rt, ext;
    logic [31:0] jt, btg;
  } stim_t;

  typedef struct {
    bit          stall, jcs, flush, bub, chk_bub, pc_known;
    logic [31:0] npc, pc;
    longint      sc, rc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] pend_q[$];
  longint      m_sc = 0, m_rc = 0;
  logic [31:0] m_pc = '0;
  bit          m_pc_known = 0;
  int          n_cmp = 0, n_bad = 0, cyc = 0;

  function automatic void chk(string n, logic [63:0] got,
                              logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
    end
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic stim_t idle(bit rdy);
    stim_t s;
    s = '{default: 0};
    s.rdy = rdy;
    return s;
  endfunction

  // Drive one cycle and push the spec-level expectation.
  task automatic issue(input stim_t s);
    exp_t        e;
    bit          lu;
    logic [31:0] tgt;
    @(negedge clk);
    rst = s.rst; imem_ready = s.rdy;
    id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.use_rt;
    id_jump = s.jmp; id_jump_target = s.jt;
    ex_mem_read = s.mr; ex_rt = s.ext;
    ex_branch_taken = s.bt; ex_branch_target = s.btg;
    e = '{default: 0};
    e.chk_bub = 1; e.pc = m_pc; e.pc_known = m_pc_known;
    e.sc = m_sc; e.rc = m_rc;
    if (s.rst) begin
      e.jcs = 1; e.npc = RST_PC; e.flush = 1; e.bub = 1;
      pend_q.delete();
      m_pc = RST_PC; m_pc_known = 1; m_sc = 0; m_rc = 0;
    end else begin
      if (pend_q.size() > 0) begin
        e.flush = 1; e.chk_bub = 0; e.stall = !s.rdy;
        if (s.rdy) begin
          e.jcs = 1; e.npc = pend_q.pop_front(); m_pc = e.npc;
        end
      end else if (s.bt || s.jmp) begin
        tgt = s.bt ? s.btg : s.jt;
        e.flush = 1; e.bub = s.bt;
        if (s.rdy) begin
          e.jcs = 1; e.npc = tgt; m_pc = tgt;
        end else begin
          e.stall = 1; pend_q.push_back(tgt);
        end
      end else begin
        lu = s.mr && s.ext != 0 &&
             (s.ext == s.rs || (s.use_rt && s.ext == s.rt));
        if (lu) begin
          e.stall = 1; e.bub = 1;
        end else begin
          e.stall = !s.rdy;
          if (s.rdy) m_pc = m_pc + 32'd1;
        end
      end
      m_sc += longint'(e.stall);
      m_rc += longint'(e.jcs);
    end
    sb_q.push_back(e);
  endtask

  // Monitor: pop one expectation per cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", {63'd0, stall0}, {63'd0, e.stall});
        chk("jump_cs", {63'd0, jcs0}, {63'd0, e.jcs});
        if (e.jcs) chk("Next_pc", {32'd0, npc0}, {32'd0, e.npc});
        chk("ifid_flush", {63'd0, fl0}, {63'd0, e.flush});
        if (e.chk_bub)
          chk("idex_bubble", {63'd0, bb0}, {63'd0, e.bub});
        chk("stall_count", {32'd0, sc0},
            64'(sat(e.sc, 64'hFFFF_FFFF)));
        chk("redirect_count", {32'd0, rc0},
            64'(sat(e.rc, 64'hFFFF_FFFF)));
        chk("stall_count4", {60'd0, sc1}, 64'(sat(e.sc, 15)));
        chk("redirect_count4", {60'd0, rc1}, 64'(sat(e.rc, 15)));
        if (e.pc_known) chk("pc", {32'd0, pc_q}, {32'd0, e.pc});
        cyc++;
      end
    end
  end

  initial begin
    stim_t s;
    // Reset for two cycles.
    s = idle(1); s.rst = 1;
    issue(s); issue(s);
    issue(idle(1));
    // Branch redirect to 0x100.
    s = idle(1); s.bt = 1; s.btg = 32'h100;
    issue(s); issue(idle(1));
    // Load-use on rs.
    s = idle(1); s.mr = 1; s.ext = 5'd5; s.rs = 5'd5;
    issue(s); issue(idle(1));
    // Load to r0: no stall.
    s = idle(1); s.mr = 1; s.ext = 5'd0; s.rs = 5'd0;
    issue(s);
    // Load-use on rt.
    s = idle(1); s.mr = 1; s.ext = 5'd7; s.rt = 5'd7;
    s.use_rt = 1; s.rs = 5'd3;
    issue(s);
    // Branch and jump together.
    s = idle(1); s.bt = 1; s.btg = 32'h200;
    s.jmp = 1; s.jt = 32'h300;
    issue(s); issue(idle(1));
    // Jump with a load-use in the same cycle.
    s = idle(1); s.jmp = 1; s.jt = 32'h500;
    s.mr = 1; s.ext = 5'd2; s.rs = 5'd2;
    issue(s); issue(idle(1));
    // Redirect during a 3-cycle memory wait.
    s = idle(1); s.rst = 1; issue(s);
    s = idle(0); s.bt = 1; s.btg = 32'h80;
    issue(s);
    s = idle(0); s.jmp = 1; s.jt = 32'h90;
    issue(s); issue(idle(0));
    s = idle(1); s.jmp = 1; s.jt = 32'h90;
    issue(s);
    issue(idle(1)); issue(idle(1));
    // Reset while a redirect is pending.
    s = idle(0); s.jmp = 1; s.jt = 32'h777;
    issue(s);
    s = idle(0); s.rst = 1; issue(s);
    issue(idle(1)); issue(idle(1));
    // Long wait: narrow counter saturates at 15.
    repeat (20) issue(idle(0));
    issue(idle(1));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst    = ($urandom_range(0, 99) == 0);
      s.rdy    = ($urandom_range(0, 9) < 7);
      s.bt     = ($urandom_range(0, 9) < 1);
      s.jmp    = ($urandom_range(0, 9) < 2);
      s.mr     = ($urandom_range(0, 9) < 4);
      s.use_rt = ($urandom_range(0, 1) == 1);
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.ext    = 5'($urandom_range(0, 3));
      s.jt     = $urandom;
      s.btg    = $urandom;
      issue(s);
    end
    @(negedge clk);
    @(negedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
